// File: rtl/ssd_seq_pkg.sv
// Shared types and helpers for the SSD value sequencer.
//   t_seq_state   : sequencer state encoding
//   c_word_width  : width of one sensor word
//   f_idx_width   : width of the byte index for a given word count (min 1)
//   f_magnitude   : two's-complement magnitude; 16'h8000 maps to itself
package ssd_seq_pkg;

  typedef enum logic {S_IDLE, S_SHOW} t_seq_state;

  localparam int c_word_width = 16;

  function automatic int f_idx_width(input int num_words);
    return (2 * num_words > 2) ? $clog2(2 * num_words) : 1;
  endfunction

  function automatic logic [c_word_width-1:0] f_magnitude(input logic [c_word_width-1:0] w);
    return w[c_word_width-1] ? (~w + 16'd1) : w;
  endfunction

endpackage

// File: rtl/ssd_dwell_timer.sv
// Dwell timer: counts enabled cycles and pulses o_tick on the last cycle of
// each dwell period, then restarts from 0.
//   i_clk_20mhz : clock
//   i_rst_20mhz : async active-low reset
//   i_run       : count enable (frozen when low)
//   i_clear     : synchronous restart at 0 (wins over i_run)
//   o_tick      : combinational, high on the final dwell cycle while running
module ssd_dwell_timer #(
  parameter int par_dwell_cycles = 20000000
) (
  input  logic i_clk_20mhz,
  input  logic i_rst_20mhz,
  input  logic i_run,
  input  logic i_clear,
  output logic o_tick
);

  localparam int c_cw = (par_dwell_cycles > 1) ? $clog2(par_dwell_cycles) : 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(par_dwell_cycles - 1);

  logic [c_cw-1:0] r_cnt;

  assign o_tick = i_run && (r_cnt == c_last);

  always_ff @(posedge i_clk_20mhz or negedge i_rst_20mhz) begin
    if (!i_rst_20mhz) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_run) begin
      if (r_cnt == c_last) r_cnt <= '0;
      else                 r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ssd_value_sequencer.sv
// Feeds one_pmod_ssd_display: steps through a double-buffered snapshot of
// 16-bit words one byte at a time (MSByte first), each byte held for
// par_dwell_cycles clocks.
//   i_clk_20mhz, i_rst_20mhz : clock, async active-low reset
//   i_words      : snapshot, word k at [16k+15:16k]
//   i_load       : capture strobe (active directly from idle or at a wrap,
//                  otherwise into the pending buffer)
//   i_hold       : freeze dwell counter and displayed byte
//   o_value1/0   : high/low nibble of displayed byte
//   o_byte_idx   : displayed byte index, 0 = word0 MSByte
//   o_busy       : first snapshot loaded
//   o_frame_done : one-cycle pulse with the wrap to index 0
//   o_pending    : snapshot waiting for frame end
//   o_negative   : sign of displayed word
// Build option: SSD_SEQ_SIGN_MAG_EN displays sign/magnitude instead of raw
// bytes; conversion happens at capture so display latency is unchanged.
//
// state  | meaning
// S_IDLE | nothing loaded yet, outputs held 0
// S_SHOW | cycling through the active buffer
module ssd_value_sequencer
  import ssd_seq_pkg::*;
#(
  parameter int par_num_words    = 3,
  parameter int par_dwell_cycles = 20000000
) (
  input  logic                                     i_clk_20mhz,
  input  logic                                     i_rst_20mhz,
  input  logic [c_word_width*par_num_words-1:0]    i_words,
  input  logic                                     i_load,
  input  logic                                     i_hold,
  output logic [3:0]                               o_value0,
  output logic [3:0]                               o_value1,
  output logic [f_idx_width(par_num_words)-1:0]    o_byte_idx,
  output logic                                     o_busy,
  output logic                                     o_frame_done,
  output logic                                     o_pending,
  output logic                                     o_negative
);

  localparam int c_iw = f_idx_width(par_num_words);
  localparam logic [c_iw-1:0] c_last_idx = c_iw'(2 * par_num_words - 1);

  typedef logic [par_num_words-1:0][c_word_width-1:0] t_words;

  t_words                   w_in_words, w_in_mag;
  t_words                   r_act, r_pend, w_act_nxt, w_pend_nxt;
  logic [par_num_words-1:0] w_in_neg, r_act_neg, r_pend_neg, w_act_neg_nxt, w_pend_neg_nxt;
  t_seq_state               r_state, w_state_nxt;
  logic                     r_pend_vld, w_pend_vld_nxt;
  logic [c_iw-1:0]          r_idx, w_idx_nxt;
  logic                     w_tick, w_run, w_clear, w_wrap;
  logic [7:0]               w_byte, r_byte;
  logic                     w_neg_sel, r_negative, r_busy, r_frame_done;

  assign w_in_words = i_words;

`ifdef SSD_SEQ_SIGN_MAG_EN
  always_comb begin
    w_in_mag = '0;
    w_in_neg = '0;
    for (int k = 0; k < par_num_words; k++) begin
      w_in_mag[k] = f_magnitude(w_in_words[k]);
      w_in_neg[k] = w_in_words[k][c_word_width-1];
    end
  end
`else
  assign w_in_mag = w_in_words;
  assign w_in_neg = '0;
`endif

  assign w_run   = (r_state == S_SHOW) && !i_hold;
  assign w_clear = (r_state == S_IDLE) && i_load;

  ssd_dwell_timer #(
    .par_dwell_cycles(par_dwell_cycles)
  ) u_dwell_timer (
    .i_clk_20mhz(i_clk_20mhz),
    .i_rst_20mhz(i_rst_20mhz),
    .i_run      (w_run),
    .i_clear    (w_clear),
    .o_tick     (w_tick)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_act_nxt      = r_act;
    w_act_neg_nxt  = r_act_neg;
    w_pend_nxt     = r_pend;
    w_pend_neg_nxt = r_pend_neg;
    w_pend_vld_nxt = r_pend_vld;
    w_idx_nxt      = r_idx;
    w_wrap         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_load) begin
          w_state_nxt   = S_SHOW;
          w_act_nxt     = w_in_mag;
          w_act_neg_nxt = w_in_neg;
          w_idx_nxt     = '0;
        end
      end
      default: begin
        w_wrap = w_tick && (r_idx == c_last_idx);
        if (w_tick) w_idx_nxt = w_wrap ? '0 : r_idx + 1'b1;
        if (w_wrap) begin
          // A load landing on the wrap is newer than anything pending.
          if (i_load) begin
            w_act_nxt      = w_in_mag;
            w_act_neg_nxt  = w_in_neg;
            w_pend_vld_nxt = 1'b0;
          end else if (r_pend_vld) begin
            w_act_nxt      = r_pend;
            w_act_neg_nxt  = r_pend_neg;
            w_pend_vld_nxt = 1'b0;
          end
        end else if (i_load) begin
          w_pend_nxt     = w_in_mag;
          w_pend_neg_nxt = w_in_neg;
          w_pend_vld_nxt = 1'b1;
        end
      end
    endcase
  end

  // Byte for the next cycle, taken from next-state buffer and index so the
  // registered output lines up with the index change.
  always_comb begin
    w_byte    = '0;
    w_neg_sel = 1'b0;
    for (int k = 0; k < par_num_words; k++) begin
      if ((w_idx_nxt >> 1) == c_iw'(k)) begin
        w_byte    = w_idx_nxt[0] ? w_act_nxt[k][7:0] : w_act_nxt[k][15:8];
        w_neg_sel = w_act_neg_nxt[k];
      end
    end
  end

  always_ff @(posedge i_clk_20mhz or negedge i_rst_20mhz) begin
    if (!i_rst_20mhz) begin
      r_state      <= S_IDLE;
      r_act        <= '0;
      r_act_neg    <= '0;
      r_pend       <= '0;
      r_pend_neg   <= '0;
      r_pend_vld   <= 1'b0;
      r_idx        <= '0;
      r_byte       <= '0;
      r_negative   <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_act        <= w_act_nxt;
      r_act_neg    <= w_act_neg_nxt;
      r_pend       <= w_pend_nxt;
      r_pend_neg   <= w_pend_neg_nxt;
      r_pend_vld   <= w_pend_vld_nxt;
      r_idx        <= w_idx_nxt;
      r_byte       <= w_byte;
      r_negative   <= w_neg_sel;
      r_busy       <= (w_state_nxt == S_SHOW);
      r_frame_done <= w_wrap;
    end
  end

  assign o_value1     = r_byte[7:4];
  assign o_value0     = r_byte[3:0];
  assign o_byte_idx   = r_idx;
  assign o_busy       = r_busy;
  assign o_frame_done = r_frame_done;
  assign o_pending    = r_pend_vld;
  assign o_negative   = r_negative;

endmodule

// File: tb/tb_ssd_value_sequencer.sv
module tb_ssd_value_sequencer;

  localparam int NW = 2;
  localparam int DW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_words;
  logic        i_load, i_hold;
  logic [3:0]  o_value0, o_value1;
  logic [1:0]  o_byte_idx;
  logic        o_busy, o_frame_done, o_pending, o_negative;

  ssd_value_sequencer #(
    .par_num_words   (NW),
    .par_dwell_cycles(DW)
  ) dut (
    .i_clk_20mhz (clk),
    .i_rst_20mhz (rst_n),
    .i_words     (i_words),
    .i_load      (i_load),
    .i_hold      (i_hold),
    .o_value0    (o_value0),
    .o_value1    (o_value1),
    .o_byte_idx  (o_byte_idx),
    .o_busy      (o_busy),
    .o_frame_done(o_frame_done),
    .o_pending   (o_pending),
    .o_negative  (o_negative)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] idx;
    logic [7:0] val;
    logic       neg;
    logic       fd;
    int         gap;   // cycles since previous display event, 0 = unchecked
  } t_ev;

  t_ev  q[$];
  t_ev  mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic busy_exp = 1'b0;
  logic pend_exp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Displayed form of a word: {negative, shown 16 bits}.
  function automatic logic [16:0] f_disp(input logic [15:0] w);
`ifdef SSD_SEQ_SIGN_MAG_EN
    if (w[15]) return {1'b1, 16'(~w + 16'd1)};
`endif
    return {1'b0, w};
  endfunction

  task automatic push_ev(input logic [1:0] idx, input logic [7:0] val, input logic neg,
                         input logic fd, input int gap);
    t_ev e;
    e.idx = idx; e.val = val; e.neg = neg; e.fd = fd; e.gap = gap;
    q.push_back(e);
  endtask

  task automatic push_word(input logic [1:0] idx, input logic [15:0] w, input logic fd,
                           input int gap);
    logic [16:0] d;
    d = f_disp(w);
    push_ev(idx, idx[0] ? d[7:0] : d[15:8], d[16], fd, gap);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [31:0] w);
    i_words = w;
    i_load  = 1'b1;
    tick(1);
    i_load  = 1'b0;
  endtask

  // Monitor: a display event is busy rising or the byte index changing.
  int         gap_cnt   = 0;
  logic       prev_busy = 1'b0;
  logic [1:0] prev_idx  = 2'd0;

  always @(negedge clk) begin
    gap_cnt++;
    chk("busy", {31'd0, o_busy}, {31'd0, busy_exp});
    chk("pending", {31'd0, o_pending}, {31'd0, pend_exp});
    if (!o_busy) begin
      chk("idle_outputs", {20'd0, o_value1, o_value0, o_byte_idx, o_frame_done, o_negative}, 32'd0);
    end else if (!prev_busy || o_byte_idx != prev_idx) begin
      if (q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_event: idx %0d value %h%h, nothing expected", o_byte_idx,
                 o_value1, o_value0);
      end else begin
        mon_e = q.pop_front();
        chk("byte_idx", {30'd0, o_byte_idx}, {30'd0, mon_e.idx});
        chk("value", {24'd0, o_value1, o_value0}, {24'd0, mon_e.val});
        chk("negative", {31'd0, o_negative}, {31'd0, mon_e.neg});
        chk("frame_done", {31'd0, o_frame_done}, {31'd0, mon_e.fd});
        if (mon_e.gap != 0) chk("dwell_gap", gap_cnt, mon_e.gap);
      end
      gap_cnt = 0;
    end else begin
      chk("frame_done_quiet", {31'd0, o_frame_done}, 32'd0);
    end
    prev_busy = o_busy;
    prev_idx  = o_byte_idx;
  end

  initial begin
    rst_n   = 1'b0;
    i_words = '0;
    i_load  = 1'b0;
    i_hold  = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(3);

    // Frame of A, then B loaded at index 1 goes to pending until the wrap.
    push_word(0, 16'h1234, 0, 0); push_word(1, 16'h1234, 0, DW);
    push_word(2, 16'hBEEF, 0, DW); push_word(3, 16'hBEEF, 0, DW);
    push_word(0, 16'h1234, 1, DW); push_word(1, 16'h1234, 0, DW);
    push_word(2, 16'hBEEF, 0, DW); push_word(3, 16'hBEEF, 0, DW);
    // B frame; hold at index 2 stretches that byte to 4+10 cycles.
    push_word(0, 16'h7788, 1, DW); push_word(1, 16'h7788, 0, DW);
    push_word(2, 16'h5566, 0, DW); push_word(3, 16'h5566, 0, DW + 10);
    push_word(0, 16'h7788, 1, DW); push_word(1, 16'h7788, 0, DW);
    push_word(2, 16'h5566, 0, DW); push_word(3, 16'h5566, 0, DW);
    // C loaded on the wrap cycle: shown immediately, never pending.
    push_word(0, 16'hD00D, 1, DW); push_word(1, 16'hD00D, 0, DW);
    push_word(2, 16'hCAFE, 0, DW); push_word(3, 16'hCAFE, 0, DW);

    do_load({16'hBEEF, 16'h1234});           // load edge L
    busy_exp = 1'b1;
    tick(20);                                // L+20: index 1 of second frame
    do_load({16'h5566, 16'h7788});           // L+21
    pend_exp = 1'b1;
    tick(11);                                // L+32: wrap swaps in B
    pend_exp = 1'b0;
    tick(9);                                 // L+41: one dwell cycle into index 2
    i_hold = 1'b1;
    tick(10);
    i_hold = 1'b0;                           // L+51
    tick(22);                                // L+73
    do_load({16'hCAFE, 16'hD00D});           // captured on the L+74 wrap
    tick(12);                                // L+86: index 3 of C
    do_load({16'h9999, 16'h9999});           // goes to pending, then discarded
    pend_exp = 1'b1;
    #3;
    rst_n    = 1'b0;
    busy_exp = 1'b0;
    pend_exp = 1'b0;
    #1;
    chk("async_reset", {20'd0, o_value1, o_value0, o_byte_idx, o_busy, o_frame_done,
                        o_pending, o_negative}, 32'd0);
    chk("queue_drained_a", q.size(), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(3);

    // After reset only the new load is shown; discarded pending never appears.
    push_word(0, 16'h0304, 0, 0); push_word(1, 16'h0304, 0, DW);
    push_word(2, 16'h0102, 0, DW); push_word(3, 16'h0102, 0, DW);
    push_word(0, 16'h0304, 1, DW);
    do_load({16'h0102, 16'h0304});
    busy_exp = 1'b1;
    tick(17);
    chk("queue_drained_e", q.size(), 32'd0);
    rst_n    = 1'b0;
    busy_exp = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Negative words: sign/magnitude when enabled, raw bytes otherwise.
`ifdef SSD_SEQ_SIGN_MAG_EN
    push_ev(0, 8'h00, 1, 0, 0); push_ev(1, 8'h02, 1, 0, DW);
    push_ev(2, 8'h80, 1, 0, DW); push_ev(3, 8'h00, 1, 0, DW);
    push_ev(0, 8'h00, 1, 1, DW);
`else
    push_ev(0, 8'hFF, 0, 0, 0); push_ev(1, 8'hFE, 0, 0, DW);
    push_ev(2, 8'h80, 0, 0, DW); push_ev(3, 8'h00, 0, 0, DW);
    push_ev(0, 8'hFF, 0, 1, DW);
`endif
    do_load({16'h8000, 16'hFFFE});
    busy_exp = 1'b1;
    tick(17);
    chk("queue_drained_s", q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
